// File: rtl/link_addr_manager.sv
// Page-number FIFO serving a link controller's table requests.
// Optionally self-fills with pages 0..DEPTH-1 after reset (free-page table).
module link_addr_manager #(
    parameter int ADDR_PAGE_NUM_LOG = 12,
    parameter bit INIT_FULL         = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_req,
    input  logic                         write_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0] write_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] read_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] read_last_addr,
    output logic                         empty,
    output logic                         full,
    output logic [ADDR_PAGE_NUM_LOG:0]   count,
    output logic                         init_done,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int L     = ADDR_PAGE_NUM_LOG;
    localparam int DEPTH = 2 ** L;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [L:0]   rd_ptr_q, rd_ptr_d;
    logic [L:0]   wr_ptr_q, wr_ptr_d;
    logic [L-1:0] last_q, last_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic [L-1:0] mem [DEPTH];
    logic         mem_we;
    logic [L-1:0] mem_waddr;
    logic [L-1:0] mem_wdata;

    logic ptr_eq;
    logic ptr_full;
    logic do_pop;
    logic do_push;
    logic blocked;

    assign ptr_eq   = (rd_ptr_q == wr_ptr_q);
    assign ptr_full = (rd_ptr_q[L] != wr_ptr_q[L]) &&
                      (rd_ptr_q[L-1:0] == wr_ptr_q[L-1:0]);

    // A pop at full frees the slot the simultaneous push lands in.
    assign do_pop  = read_req & ~ptr_eq;
    assign do_push = write_req & (~ptr_full | do_pop);

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        last_d    = last_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q[L-1:0];
        mem_wdata = write_addr;
        unique case (state_q)
            FILL: begin
                if (INIT_FULL) begin
                    mem_we    = 1'b1;
                    mem_wdata = wr_ptr_q[L-1:0];
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    last_d    = wr_ptr_q[L-1:0];
                    if (wr_ptr_q[L-1:0] == {L{1'b1}}) begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (do_pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (do_push) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    last_d   = write_addr;
                end
                if (write_req && !do_push) begin
                    ovf_d = 1'b1;
                end
                if (read_req && ptr_eq) begin
                    unf_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Requests are invisible to the controller until the fill is done.
    assign blocked        = rst | (state_q == FILL);
    assign empty          = blocked | ptr_eq;
    assign full           = ~blocked & ptr_full;
    assign read_addr      = empty ? '0 : mem[rd_ptr_q[L-1:0]];
    assign read_last_addr = last_q;
    assign count          = wr_ptr_q - rd_ptr_q;
    assign init_done      = (state_q == RUN);
    assign overflow_err   = ovf_q;
    assign underflow_err  = unf_q;

endmodule

// File: tb/tb_link_addr_manager.sv
// Bench for link_addr_manager: one free-page instance and one data instance.
// Popped heads are checked by per-instance monitors against expected queues.
module tb_link_addr_manager;

    localparam int L = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic         a_rst = 1'b0, a_rd = 1'b0, a_wr = 1'b0;
    logic [L-1:0] a_wa = '0;
    logic [L-1:0] a_ra, a_last;
    logic         a_empty, a_full, a_done, a_ovf, a_unf;
    logic [L:0]   a_cnt;

    logic         b_rst = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [L-1:0] b_wa = '0;
    logic [L-1:0] b_ra, b_last;
    logic         b_empty, b_full, b_done, b_ovf, b_unf;
    logic [L:0]   b_cnt;

    int qa[$];
    int qb[$];

    link_addr_manager #(.ADDR_PAGE_NUM_LOG(L), .INIT_FULL(1'b1)) u_a (
        .clk(clk), .rst(a_rst), .read_req(a_rd), .write_req(a_wr),
        .write_addr(a_wa), .read_addr(a_ra), .read_last_addr(a_last),
        .empty(a_empty), .full(a_full), .count(a_cnt),
        .init_done(a_done), .overflow_err(a_ovf), .underflow_err(a_unf)
    );

    link_addr_manager #(.ADDR_PAGE_NUM_LOG(L), .INIT_FULL(1'b0)) u_b (
        .clk(clk), .rst(b_rst), .read_req(b_rd), .write_req(b_wr),
        .write_addr(b_wa), .read_addr(b_ra), .read_last_addr(b_last),
        .empty(b_empty), .full(b_full), .count(b_cnt),
        .init_done(b_done), .overflow_err(b_ovf), .underflow_err(b_unf)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!a_rst && a_rd && !a_empty) begin
            if (qa.size() == 0) check("a_pop_unexpected", 32'(a_ra), 32'hFFFF);
            else check("a_pop_head", 32'(a_ra), 32'(qa.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!b_rst && b_rd && !b_empty) begin
            if (qb.size() == 0) check("b_pop_unexpected", 32'(b_ra), 32'hFFFF);
            else check("b_pop_head", 32'(b_ra), 32'(qb.pop_front()));
        end
    end

    task automatic a_cyc(input logic rd, input logic wr, input int wa);
        @(posedge clk); #1;
        a_rd = rd; a_wr = wr; a_wa = L'(wa);
    endtask

    task automatic b_cyc(input logic rd, input logic wr, input int wa);
        @(posedge clk); #1;
        b_rd = rd; b_wr = wr; b_wa = L'(wa);
    endtask

    task automatic a_fill_check();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("a_fill_empty", 32'(a_empty), 1);
            check("a_fill_not_done", 32'(a_done), 0);
        end
        @(negedge clk);
        check("a_init_done", 32'(a_done), 1);
        check("a_init_full", 32'(a_full), 1);
        check("a_init_count", 32'(a_cnt), 8);
        check("a_init_head", 32'(a_ra), 0);
        check("a_init_last", 32'(a_last), 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: free-page table fill
        @(posedge clk); #1;
        a_rst = 1'b1; b_rst = 1'b1;
        @(negedge clk);
        check("a_rst_empty", 32'(a_empty), 1);
        check("a_rst_full", 32'(a_full), 0);
        check("a_rst_head", 32'(a_ra), 0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;
        a_fill_check();
        check("a_init_ovf", 32'(a_ovf), 0);
        check("a_init_unf", 32'(a_unf), 0);

        // Test 2: three pops
        for (int i = 0; i < 3; i++) qa.push_back(i);
        repeat (3) a_cyc(1, 0, 0);
        a_cyc(0, 0, 0);
        @(negedge clk);
        check("a_pop3_head", 32'(a_ra), 3);
        check("a_pop3_count", 32'(a_cnt), 5);
        check("a_pop3_full", 32'(a_full), 0);

        // Test 6: reset during fill restarts from page 0
        @(posedge clk); #1;
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_fill_check();
        for (int i = 0; i < 8; i++) qa.push_back(i);
        repeat (8) a_cyc(1, 0, 0);
        a_cyc(0, 0, 0);
        @(negedge clk);
        check("a_drain_empty", 32'(a_empty), 1);
        check("a_drain_unf", 32'(a_unf), 0);
        a_cyc(1, 0, 0);
        a_cyc(0, 0, 0);
        @(negedge clk);
        check("a_underflow", 32'(a_unf), 1);
        check("a_underflow_count", 32'(a_cnt), 0);

        // Data table: starts empty
        repeat (2) b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_init_done", 32'(b_done), 1);
        check("b_init_empty", 32'(b_empty), 1);
        check("b_init_count", 32'(b_cnt), 0);

        // Test 3: push 5,2,6 then pop them
        b_cyc(0, 1, 5);
        b_cyc(0, 1, 2);
        @(negedge clk);
        check("b_first_push_empty", 32'(b_empty), 0);
        check("b_first_push_head", 32'(b_ra), 5);
        b_cyc(0, 1, 6);
        b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_push3_last", 32'(b_last), 6);
        check("b_push3_count", 32'(b_cnt), 3);
        qb.push_back(5); qb.push_back(2); qb.push_back(6);
        repeat (3) b_cyc(1, 0, 0);
        b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_pop3_empty", 32'(b_empty), 1);

        // Test 4: simultaneous pop and push while empty
        b_cyc(1, 1, 4);
        b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_rw_empty_count", 32'(b_cnt), 1);
        check("b_rw_empty_head", 32'(b_ra), 4);
        check("b_rw_empty_unf", 32'(b_unf), 1);
        qb.push_back(4);
        b_cyc(1, 0, 0);

        // Test 5: full list, overflow, then pop+push at full
        for (int i = 0; i < 8; i++) b_cyc(0, 1, i);
        b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_fill_full", 32'(b_full), 1);
        check("b_fill_count", 32'(b_cnt), 8);
        check("b_fill_ovf", 32'(b_ovf), 0);
        b_cyc(0, 1, 3);
        b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_overflow", 32'(b_ovf), 1);
        check("b_overflow_count", 32'(b_cnt), 8);
        check("b_overflow_last", 32'(b_last), 7);
        qb.push_back(0);
        b_cyc(1, 1, 3);
        b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_rw_full_count", 32'(b_cnt), 8);
        check("b_rw_full_head", 32'(b_ra), 1);
        check("b_rw_full_last", 32'(b_last), 3);
        check("b_rw_full_full", 32'(b_full), 1);
        for (int i = 1; i < 8; i++) qb.push_back(i);
        qb.push_back(3);
        repeat (8) b_cyc(1, 0, 0);
        b_cyc(0, 0, 0);
        @(negedge clk);
        check("b_final_empty", 32'(b_empty), 1);

        check("a_queue_drained", 32'(qa.size()), 0);
        check("b_queue_drained", 32'(qb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
